// File: rtl/llc_mem_bridge_pkg.sv
// Shared constants, types and state encoding for the LLC memory bridge.
// Line address plus byte offset is truncated to the memory port address width.
package llc_mem_bridge_pkg;

  localparam int unsigned WordsPerLine = 4;
  localparam int unsigned BitsPerWord  = 64;
  localparam int unsigned LineAddrBits = 28;
  localparam int unsigned AddrBits     = 32;
  localparam int unsigned HprotBits    = 2;
  localparam int unsigned LineBits     = WordsPerLine * BitsPerWord;
  localparam int unsigned OffsetBits   = $clog2(WordsPerLine * BitsPerWord / 8);
  localparam int unsigned CntBits      = $clog2(WordsPerLine);

  typedef logic [BitsPerWord-1:0]  word_t;
  typedef logic [LineBits-1:0]     line_t;
  typedef word_t [WordsPerLine-1:0] line_words_t;
  typedef logic [LineAddrBits-1:0] line_addr_t;
  typedef logic [AddrBits-1:0]     addr_t;
  typedef logic [HprotBits-1:0]    hprot_t;
  typedef logic [CntBits-1:0]      beat_cnt_t;

  localparam beat_cnt_t LastBeat = beat_cnt_t'(WordsPerLine - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWdata,
    StRdata,
    StRsp
  } bridge_state_e;

  function automatic addr_t line_base(input line_addr_t line_addr);
    logic [LineAddrBits+OffsetBits-1:0] full;
    full = {line_addr, {OffsetBits{1'b0}}};
    return addr_t'(full);
  endfunction

endpackage

// File: rtl/llc_mem_line_buf.sv
// Line register: whole-line load for writebacks, per-word store for read gather,
// and a word-select mux for serialising writeback beats.
module llc_mem_line_buf
  import llc_mem_bridge_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      load_i,
  input  line_t     line_i,
  input  logic      we_i,
  input  beat_cnt_t idx_i,
  input  word_t     word_i,
  output line_t     line_o,
  output word_t     word_o
);

  line_words_t words_q, words_d;

  always_comb begin
    words_d = words_q;
    if (load_i) begin
      words_d = line_words_t'(line_i);
    end else if (we_i) begin
      words_d[idx_i] = word_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      words_q <= '0;
    end else begin
      words_q <= words_d;
    end
  end

  assign line_o = line_t'(words_q);
  assign word_o = words_q[idx_i];

endmodule

// File: rtl/llc_mem_bridge.sv
// Bridges line-granular LLC memory requests onto a word-beat burst memory port.
// All outputs come from registers or state decode; none depend on inputs combinationally.
module llc_mem_bridge
  import llc_mem_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       llc_mem_req_valid,
  output logic       llc_mem_req_ready,
  input  logic       llc_mem_req_hwrite,
  input  line_addr_t llc_mem_req_addr,
  input  hprot_t     llc_mem_req_hprot,
  input  line_t      llc_mem_req_line,
  output logic       llc_mem_rsp_valid,
  input  logic       llc_mem_rsp_ready,
  output line_t      llc_mem_rsp_line,
  output logic       mem_cmd_valid,
  input  logic       mem_cmd_ready,
  output logic       mem_cmd_write,
  output addr_t      mem_cmd_addr,
  output hprot_t     mem_cmd_hprot,
  output logic       mem_wdata_valid,
  input  logic       mem_wdata_ready,
  output word_t      mem_wdata,
  output logic       mem_wdata_last,
  input  logic       mem_rdata_valid,
  output logic       mem_rdata_ready,
  input  word_t      mem_rdata,
  input  logic       mem_rdata_last,
  output logic       err
);

  bridge_state_e state_q, state_d;
  beat_cnt_t     cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          hwrite_q, hwrite_d;
  line_addr_t    addr_q, addr_d;
  hprot_t        hprot_q, hprot_d;
  logic          err_q, err_d;
  logic          buf_load, buf_we;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hwrite_d = hwrite_q;
    addr_d   = addr_q;
    hprot_d  = hprot_q;
    err_d    = err_q;
    buf_load = 1'b0;
    buf_we   = 1'b0;
    case (state_q)
      StIdle: begin
        // ready is registered so the first cycle out of reset does not accept
        if (llc_mem_req_valid && req_ready_q) begin
          hwrite_d = llc_mem_req_hwrite;
          addr_d   = llc_mem_req_addr;
          hprot_d  = llc_mem_req_hprot;
          buf_load = llc_mem_req_hwrite;
          state_d  = StCmd;
        end
      end
      StCmd: begin
        if (mem_cmd_ready) begin
          cnt_d   = '0;
          state_d = hwrite_q ? StWdata : StRdata;
        end
      end
      StWdata: begin
        if (mem_wdata_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            state_d = StIdle;
          end
        end
      end
      StRdata: begin
        if (mem_rdata_valid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          // beat count, not the memory's last flag, decides completion
          if (mem_rdata_last != (cnt_q == LastBeat)) begin
            err_d = 1'b1;
          end
          if (cnt_q == LastBeat) begin
            state_d = StRsp;
          end
        end
      end
      StRsp: begin
        if (llc_mem_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      hwrite_q    <= 1'b0;
      addr_q      <= '0;
      hprot_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      hwrite_q    <= hwrite_d;
      addr_q      <= addr_d;
      hprot_q     <= hprot_d;
      err_q       <= err_d;
    end
  end

  llc_mem_line_buf u_line_buf (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (buf_load),
    .line_i (llc_mem_req_line),
    .we_i   (buf_we),
    .idx_i  (cnt_q),
    .word_i (mem_rdata),
    .line_o (llc_mem_rsp_line),
    .word_o (mem_wdata)
  );

  assign llc_mem_req_ready = req_ready_q;
  assign llc_mem_rsp_valid = (state_q == StRsp);
  assign mem_cmd_valid     = (state_q == StCmd);
  assign mem_cmd_write     = hwrite_q;
  assign mem_cmd_addr      = line_base(addr_q);
  assign mem_cmd_hprot     = hprot_q;
  assign mem_wdata_valid   = (state_q == StWdata);
  assign mem_wdata_last    = (state_q == StWdata) && (cnt_q == LastBeat);
  assign mem_rdata_ready   = (state_q == StRdata);
  assign err               = err_q;

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Scoreboard bench for llc_mem_bridge: directed requests push expectations,
// a monitor compares every command, write beat and fill response handshake.
module tb_llc_mem_bridge;
  import llc_mem_bridge_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       llc_mem_req_valid, llc_mem_req_ready, llc_mem_req_hwrite;
  line_addr_t llc_mem_req_addr;
  hprot_t     llc_mem_req_hprot;
  line_t      llc_mem_req_line;
  logic       llc_mem_rsp_valid, llc_mem_rsp_ready;
  line_t      llc_mem_rsp_line;
  logic       mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  addr_t      mem_cmd_addr;
  hprot_t     mem_cmd_hprot;
  logic       mem_wdata_valid, mem_wdata_ready, mem_wdata_last;
  word_t      mem_wdata;
  logic       mem_rdata_valid, mem_rdata_ready, mem_rdata_last;
  word_t      mem_rdata;
  logic       err;

  llc_mem_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .llc_mem_req_valid (llc_mem_req_valid),
    .llc_mem_req_ready (llc_mem_req_ready),
    .llc_mem_req_hwrite(llc_mem_req_hwrite),
    .llc_mem_req_addr  (llc_mem_req_addr),
    .llc_mem_req_hprot (llc_mem_req_hprot),
    .llc_mem_req_line  (llc_mem_req_line),
    .llc_mem_rsp_valid (llc_mem_rsp_valid),
    .llc_mem_rsp_ready (llc_mem_rsp_ready),
    .llc_mem_rsp_line  (llc_mem_rsp_line),
    .mem_cmd_valid     (mem_cmd_valid),
    .mem_cmd_ready     (mem_cmd_ready),
    .mem_cmd_write     (mem_cmd_write),
    .mem_cmd_addr      (mem_cmd_addr),
    .mem_cmd_hprot     (mem_cmd_hprot),
    .mem_wdata_valid   (mem_wdata_valid),
    .mem_wdata_ready   (mem_wdata_ready),
    .mem_wdata         (mem_wdata),
    .mem_wdata_last    (mem_wdata_last),
    .mem_rdata_valid   (mem_rdata_valid),
    .mem_rdata_ready   (mem_rdata_ready),
    .mem_rdata         (mem_rdata),
    .mem_rdata_last    (mem_rdata_last),
    .err               (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_cmd_q[$];  // {write, addr, hprot}
  logic [64:0] exp_w_q[$];    // {last, data}
  line_t       exp_rsp_q[$];
  logic [64:0] rbeat_q[$];    // beats the memory model will return

  int cmd_wait = 0;
  bit wtoggle  = 1'b0;
  bit spurious = 1'b0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Memory model: inputs change on the falling edge only.
  initial begin : mem_model
    int cw;
    bit wph;
    cw = 0;
    wph = 1'b1;
    mem_cmd_ready = 1'b0;
    mem_wdata_ready = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata = '0;
    mem_rdata_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!mem_cmd_valid) begin
        cw = cmd_wait;
        mem_cmd_ready = 1'b0;
      end else begin
        mem_cmd_ready = (cw == 0);
        if (cw > 0) cw--;
      end
      if (wtoggle) begin
        if (mem_wdata_valid) begin
          mem_wdata_ready = wph;
          wph = !wph;
        end else begin
          wph = 1'b1;
          mem_wdata_ready = 1'b0;
        end
      end else begin
        mem_wdata_ready = 1'b1;
      end
      if (mem_rdata_ready && rbeat_q.size() > 0) begin
        {mem_rdata_last, mem_rdata} = rbeat_q.pop_front();
        mem_rdata_valid = 1'b1;
      end else if (spurious) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        mem_rdata_last = 1'b1;
      end else begin
        mem_rdata_valid = 1'b0;
      end
    end
  end

  // Monitor: looks just after the falling edge at handshakes due on the next rising edge.
  initial begin : monitor
    bit          cmd_stall, rsp_stall;
    logic [34:0] prev_cmd;
    line_t       prev_rsp;
    cmd_stall = 1'b0;
    rsp_stall = 1'b0;
    prev_cmd = '0;
    prev_rsp = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        cmd_stall = 1'b0;
        rsp_stall = 1'b0;
        continue;
      end
      if (cmd_stall)
        check("cmd_stable", 320'({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_hprot}),
              320'({1'b1, prev_cmd}));
      if (rsp_stall)
        check("rsp_stable", 320'({llc_mem_rsp_valid, llc_mem_rsp_line}), 320'({1'b1, prev_rsp}));
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (exp_cmd_q.size() == 0) unexpected("cmd_unexpected");
        else check("cmd", 320'({mem_cmd_write, mem_cmd_addr, mem_cmd_hprot}),
                   320'(exp_cmd_q.pop_front()));
      end
      if (mem_wdata_valid && mem_wdata_ready) begin
        if (exp_w_q.size() == 0) unexpected("wdata_unexpected");
        else check("wdata", 320'({mem_wdata_last, mem_wdata}), 320'(exp_w_q.pop_front()));
      end
      if (llc_mem_rsp_valid && llc_mem_rsp_ready) begin
        if (exp_rsp_q.size() == 0) unexpected("rsp_unexpected");
        else check("rsp_line", 320'(llc_mem_rsp_line), 320'(exp_rsp_q.pop_front()));
      end
      cmd_stall = mem_cmd_valid && !mem_cmd_ready;
      prev_cmd  = {mem_cmd_write, mem_cmd_addr, mem_cmd_hprot};
      rsp_stall = llc_mem_rsp_valid && !llc_mem_rsp_ready;
      prev_rsp  = llc_mem_rsp_line;
    end
  end

  // Returns the rising-edge count at which the request was taken.
  task automatic issue(input logic hw, input line_addr_t a, input hprot_t hp, input line_t ln,
                       output int acc);
    int n = 0;
    while (!llc_mem_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!llc_mem_req_ready) unexpected("req_ready_timeout");
    llc_mem_req_valid  = 1'b1;
    llc_mem_req_hwrite = hw;
    llc_mem_req_addr   = a;
    llc_mem_req_hprot  = hp;
    llc_mem_req_line   = ln;
    @(negedge clk);
    acc = cyc;
    llc_mem_req_valid = 1'b0;
    llc_mem_req_line  = '0;
  endtask

  task automatic wait_rsp(output int t);
    int n = 0;
    while (!llc_mem_rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!llc_mem_rsp_valid) unexpected("rsp_timeout");
    t = cyc;
  endtask

  task automatic wait_idle(output int t);
    int n = 0;
    while (!llc_mem_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!llc_mem_req_ready) unexpected("idle_timeout");
    t = cyc;
  endtask

  // Queues a read of four beats base+k; last flag on beat early_idx and on the final beat.
  task automatic push_read(input line_addr_t a, input hprot_t hp, input logic [63:0] base,
                           input int early_idx, input bit push_rsp);
    line_t ln;
    ln = '0;
    exp_cmd_q.push_back({1'b0, line_base(a), hp});
    for (int k = 0; k < 4; k++) begin
      ln[k*64 +: 64] = base + 64'(k);
      rbeat_q.push_back({(k == 3) || (k == early_idx), base + 64'(k)});
    end
    if (push_rsp) exp_rsp_q.push_back(ln);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int    acc, t;
    line_t wl;
    rst = 1'b1;
    llc_mem_req_valid = 1'b0;
    llc_mem_req_hwrite = 1'b0;
    llc_mem_req_addr = '0;
    llc_mem_req_hprot = '0;
    llc_mem_req_line = '0;
    llc_mem_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 320'(llc_mem_req_ready), 320'(0));
    check("rst_valids", 320'({mem_cmd_valid, mem_wdata_valid, mem_rdata_ready, llc_mem_rsp_valid}),
          320'(0));
    check("rst_err", 320'(err), 320'(0));
    check("rst_line", 320'(llc_mem_rsp_line), 320'(0));
    rst = 1'b0;

    // Zero-wait read: 0x123 -> byte address 0x2460, fill visible five edges after accept.
    push_read(28'h0000123, 2'b01, 64'hA0, -1, 1'b1);
    issue(1'b0, 28'h0000123, 2'b01, '0, acc);
    wait_rsp(t);
    check("rd_latency", 320'(t - acc), 320'(5));
    check("rd_err", 320'(err), 320'(0));

    // Writeback with toggling beat ready: D0..D3 in order, last only on D3.
    wl = '0;
    for (int k = 0; k < 4; k++) begin
      wl[k*64 +: 64] = 64'hD0 + 64'(k);
      exp_w_q.push_back({k == 3, 64'hD0 + 64'(k)});
    end
    exp_cmd_q.push_back({1'b1, 32'h0000_0020, 2'b10});
    wtoggle = 1'b1;
    issue(1'b1, 28'h0000001, 2'b10, wl, acc);
    wait_idle(t);
    check("wr_toggle_wdata_done", 320'(exp_w_q.size()), 320'(0));
    wtoggle = 1'b0;

    // Zero-wait writeback returns to idle five edges after accept.
    for (int k = 0; k < 4; k++) begin
      wl[k*64 +: 64] = 64'h5500 + 64'(k);
      exp_w_q.push_back({k == 3, 64'h5500 + 64'(k)});
    end
    exp_cmd_q.push_back({1'b1, 32'hFFFF_FFE0, 2'b11});
    issue(1'b1, 28'hFFFFFFF, 2'b11, wl, acc);
    @(negedge clk);
    wait_idle(t);
    check("wr_latency", 320'(t - acc), 320'(5));

    // Fill held while the LLC stalls; request side stays closed.
    llc_mem_rsp_ready = 1'b0;
    push_read(28'h0ABCDEF, 2'b00, 64'hB0, -1, 1'b1);
    issue(1'b0, 28'h0ABCDEF, 2'b00, '0, acc);
    wait_rsp(t);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", 320'(llc_mem_rsp_valid), 320'(1));
      check("stall_req_ready", 320'(llc_mem_req_ready), 320'(0));
      @(negedge clk);
    end
    llc_mem_rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rsp_valid", 320'(llc_mem_rsp_valid), 320'(0));
    check("post_rsp_req_ready", 320'(llc_mem_req_ready), 320'(1));

    // Early last flag on beat 1: sticky error, completion still after four beats.
    push_read(28'h0000200, 2'b01, 64'hC0, 1, 1'b1);
    issue(1'b0, 28'h0000200, 2'b01, '0, acc);
    wait_rsp(t);
    check("early_last_latency", 320'(t - acc), 320'(5));
    check("early_last_err", 320'(err), 320'(1));

    // Command stalled ten cycles with junk read beats offered during CMD.
    cmd_wait = 10;
    spurious = 1'b1;
    push_read(28'h0000300, 2'b10, 64'hF0, -1, 1'b1);
    issue(1'b0, 28'h0000300, 2'b10, '0, acc);
    for (int i = 0; i < 8; i++) begin
      check("cmd_stall_valid", 320'(mem_cmd_valid), 320'(1));
      check("cmd_stall_rdata_ready", 320'(mem_rdata_ready), 320'(0));
      @(negedge clk);
    end
    wait_rsp(t);
    spurious = 1'b0;
    cmd_wait = 0;
    @(negedge clk);
    check("err_sticky", 320'(err), 320'(1));

    // Reset after two of four beats: no response, err cleared, next read uses fresh data.
    exp_cmd_q.push_back({1'b0, line_base(28'h0000400), 2'b00});
    rbeat_q.push_back({1'b0, 64'h77});
    rbeat_q.push_back({1'b0, 64'h78});
    wait_idle(t);
    issue(1'b0, 28'h0000400, 2'b00, '0, acc);
    t = 0;
    while (rbeat_q.size() > 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valids", 320'({mem_cmd_valid, mem_wdata_valid, mem_rdata_ready,
                                 llc_mem_rsp_valid, llc_mem_req_ready}), 320'(0));
    check("midrst_err", 320'(err), 320'(0));
    rst = 1'b0;
    rbeat_q.delete();
    push_read(28'h0000500, 2'b01, 64'hE0, -1, 1'b1);
    issue(1'b0, 28'h0000500, 2'b01, '0, acc);
    wait_rsp(t);
    check("fresh_latency", 320'(t - acc), 320'(5));
    @(negedge clk);
    check("fresh_err", 320'(err), 320'(0));

    t = 0;
    while ((exp_cmd_q.size() + exp_w_q.size() + exp_rsp_q.size()) > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("exp_cmd_drained", 320'(exp_cmd_q.size()), 320'(0));
    check("exp_wdata_drained", 320'(exp_w_q.size()), 320'(0));
    check("exp_rsp_drained", 320'(exp_rsp_q.size()), 320'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
